id_gen: RTL

ID_GEN -- requirements
Module: id_gen

---
 rtl/id_gen_pkg.sv | 26 ++
 rtl/id_weight_lut.sv | 46 ++++
 rtl/id_gen.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/id_gen_pkg.sv
// rtl/id_gen_pkg.sv - shared types and constants for the ID generator
//
// Purpose : FSM state encoding, ID geometry and digit weighting used by
//           id_gen and id_weight_lut.
// Contents: state_t, N_IN, N_OUT, LETTER_MIN, LETTER_MAX, DIGIT_WEIGHT.

package id_gen_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2,
      ERR  = 2'd3
   } state_t;

   localparam int N_IN       = 9;   // letter + 8 digits accepted
   localparam int N_OUT      = 10;  // letter + 8 digits + check digit streamed
   localparam int LETTER_MIN = 10;
   localparam int LETTER_MAX = 35;

   // Weight of each input position; position 0 (the letter) uses its own
   // tens/units rule, so its entry is unused.
   localparam logic [3:0] DIGIT_WEIGHT [N_IN] =
      '{4'd0, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};

endpackage

// File: rtl/id_weight_lut.sv
// rtl/id_weight_lut.sv - mod-10 contribution and legality of one ID symbol
//
// Purpose : combinational lookup of a symbol's contribution to the running
//           check sum, plus whether the symbol is legal at its position.
// Ports   : pos     in  4  symbol position (0 = letter, 1..8 = digits)
//           sym     in  6  symbol value
//           contrib out 4  contribution mod 10
//           legal   out 1  symbol is in range for its position

module id_weight_lut
   import id_gen_pkg::*;
(
   input  logic [3:0] pos,
   input  logic [5:0] sym,
   output logic [3:0] contrib,
   output logic       legal
);

   logic [5:0] tens;
   logic [5:0] units;
   logic [7:0] letter_raw;
   logic [9:0] digit_raw;
   logic [3:0] weight;

   always_comb begin
      tens       = sym / 6'd10;
      units      = sym % 6'd10;
      letter_raw = {2'b00, tens} + 8'd9 * {2'b00, units};

      // Explicit match keeps out-of-range positions from indexing the table.
      weight = 4'd0;
      for (int i = 0; i < N_IN; i++) begin
         if (pos == 4'(i)) weight = DIGIT_WEIGHT[i];
      end
      digit_raw = {4'b0000, sym} * {6'b000000, weight};

      if (pos == 4'd0) begin
         contrib = 4'(letter_raw % 8'd10);
         legal   = (sym >= 6'(LETTER_MIN)) && (sym <= 6'(LETTER_MAX));
      end else begin
         contrib = 4'(digit_raw % 10'd10);
         legal   = (sym <= 6'd9);
      end
   end

endmodule

// File: rtl/id_gen.sv
// rtl/id_gen.sv - collects a letter+8 digit ID and streams it with a check digit
//
// Purpose : accepts 9 symbols, keeps a weighted mod-10 sum, then either
//           streams letter, digits and check digit over 10 cycles or pulses
//           out_err when any symbol was out of range.
// Ports   : clk       in  1  clock, rising edge
//           rst_n     in  1  asynchronous active-low reset
//           in_valid  in  1  in_sym valid
//           in_sym    in  6  letter code (first) or digit
//           in_ready  out 1  block accepts input (IDLE/LOAD)
//           out_valid out 1  out_sym valid
//           out_sym   out 6  streamed symbol, 0 when not valid
//           out_err   out 1  one-cycle pulse on rejected ID

module id_gen
   import id_gen_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [5:0] in_sym,
   output logic       in_ready,
   output logic       out_valid,
   output logic [5:0] out_sym,
   output logic       out_err
);

   state_t     state;
   logic [3:0] count;
   logic [3:0] sum;
   logic       err_flag;
   logic [5:0] id_buf [N_IN];

   logic [3:0] lut_pos;
   logic [3:0] contrib;
   logic       legal;
   logic [3:0] sum_base;
   logic [4:0] sum_raw;
   logic [4:0] sum_wrap;
   logic [3:0] sum_next;
   logic [3:0] check_digit;
   logic [5:0] buf_rd;

   assign in_ready = (state == IDLE) || (state == LOAD);

   // In IDLE the incoming sample is always the letter, whatever count holds.
   assign lut_pos = (state == IDLE) ? 4'd0 : count;

   id_weight_lut u_lut (
      .pos     (lut_pos),
      .sym     (in_sym),
      .contrib (contrib),
      .legal   (legal)
   );

   always_comb begin
      sum_base    = (state == IDLE) ? 4'd0 : sum;
      sum_raw     = {1'b0, sum_base} + {1'b0, contrib};
      sum_wrap    = sum_raw - 5'd10;
      sum_next    = (sum_raw >= 5'd10) ? sum_wrap[3:0] : sum_raw[3:0];
      check_digit = (sum == 4'd0) ? 4'd0 : (4'd10 - sum);

      // Buffer read by position; count reaches 9 in SEND, which has no entry.
      buf_rd = 6'd0;
      for (int i = 0; i < N_IN; i++) begin
         if (count == 4'(i)) buf_rd = id_buf[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         count     <= 4'd0;
         sum       <= 4'd0;
         err_flag  <= 1'b0;
         out_valid <= 1'b0;
         out_sym   <= 6'd0;
         out_err   <= 1'b0;
         for (int i = 0; i < N_IN; i++) id_buf[i] <= 6'd0;
      end else begin
         out_err <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  id_buf[0] <= in_sym;
                  count     <= 4'd1;
                  sum       <= sum_next;
                  err_flag  <= ~legal;
                  state     <= LOAD;
               end
            end
            LOAD: begin
               if (!in_valid) begin
                  // Abort: partial ID is dropped silently.
                  state    <= IDLE;
                  count    <= 4'd0;
                  sum      <= 4'd0;
                  err_flag <= 1'b0;
               end else begin
                  for (int i = 1; i < N_IN; i++) begin
                     if (count == 4'(i)) id_buf[i] <= in_sym;
                  end
                  sum      <= sum_next;
                  err_flag <= err_flag | ~legal;
                  if (count == 4'(N_IN - 1)) begin
                     // Letter goes out immediately; count then walks 1..9.
                     count <= 4'd1;
                     if (err_flag || !legal) begin
                        state   <= ERR;
                        out_err <= 1'b1;
                     end else begin
                        state     <= SEND;
                        out_valid <= 1'b1;
                        out_sym   <= id_buf[0];
                     end
                  end else begin
                     count <= count + 4'd1;
                  end
               end
            end
            SEND: begin
               if (count == 4'(N_OUT)) begin
                  out_valid <= 1'b0;
                  out_sym   <= 6'd0;
                  state     <= IDLE;
                  count     <= 4'd0;
                  sum       <= 4'd0;
                  err_flag  <= 1'b0;
               end else begin
                  out_sym <= (count == 4'(N_OUT - 1)) ? {2'b00, check_digit} : buf_rd;
                  count   <= count + 4'd1;
               end
            end
            ERR: begin
               state    <= IDLE;
               count    <= 4'd0;
               sum      <= 4'd0;
               err_flag <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
